// File: rtl/pdua_periph_pkg.sv
// pdua_periph_pkg: register offsets, CTRL field positions and prescaler encoding for pdua_periph.
package pdua_periph_pkg;
  localparam logic [2:0] OFF_GPO    = 3'd0;
  localparam logic [2:0] OFF_GPI    = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_RELOAD = 3'd4;
  localparam logic [2:0] OFF_COUNT  = 3'd5;
  localparam logic [2:0] OFF_STATUS = 3'd6;
  localparam logic [2:0] OFF_ID     = 3'd7;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PSC_LO = 4;
  localparam int CTRL_PSC_HI = 5;
  localparam logic [7:0] CTRL_MASK = 8'h37;
  typedef enum logic [1:0] {PSC_DIV1, PSC_DIV4, PSC_DIV16, PSC_DIV64} psc_e;
  function automatic logic [5:0] psc_mask(psc_e p);
    return p == PSC_DIV1 ? 6'h00 : p == PSC_DIV4 ? 6'h03 : p == PSC_DIV16 ? 6'h0F : 6'h3F;
  endfunction
endpackage

// File: rtl/pdua_periph_timer.sv
// pdua_timer: prescaled 8-bit down-counter; expiry reloads (AUTO) or requests EN clear (one-shot).
module pdua_timer
  import pdua_periph_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto_rl,
  input  psc_e       psc,
  input  logic [7:0] reload,
  input  logic       cnt_we,
  input  logic [7:0] cnt_wdata,
  input  logic       ctrl_we,
  output logic [7:0] count,
  output logic       expire,
  output logic       en_clear
);
  logic [5:0] pre;
  logic       tick;
  always_comb begin
    tick     = en & ((pre & psc_mask(psc)) == psc_mask(psc));
    expire   = tick & ~cnt_we & (count == 8'h00);
    en_clear = expire & ~auto_rl;
  end
  // A direct COUNT write suppresses the whole step for that cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pre   <= '0;
      count <= '0;
    end else begin
      pre <= (en & ~ctrl_we) ? pre + 6'd1 : 6'd0;
      if (cnt_we) count <= cnt_wdata;
      else if (tick & (count != 8'h00)) count <= count - 8'd1;
      else if (expire & auto_rl) count <= reload;
    end
endmodule

// File: rtl/pdua_periph.sv
// pdua_periph: PDUA I/O-port peripheral with GPO, synchronized GPI, edge capture and timer/IRQ.
// Edge capture (EDGE register, STATUS bit1) exists only when PDUA_PERIPH_EDGE_EN is defined.
module pdua_periph
  import pdua_periph_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter logic [7:0] ID_VALUE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_bus_pr,
  input  logic       wr_rdn_pr,
  input  logic [7:0] wr_data_pr,
  output logic [7:0] rd_data_pr,
  input  logic [7:0] gpi,
  output logic [7:0] gpo,
  output logic       irq
);
  logic       hit, we;
  logic [2:0] off;
  logic       we_gpo, we_edge, we_ctrl, we_reload, we_count, we_status;
  logic [7:0] gpi_s1, gpi_s2, edge_r, ctrl, reload, count;
  logic       exp_f, expire, en_clear;
  assign hit       = addr_bus_pr[7:3] == BASE_ADDR[7:3];
  assign off       = addr_bus_pr[2:0];
  assign we        = hit & wr_rdn_pr;
  assign we_gpo    = we & (off == OFF_GPO);
  assign we_edge   = we & (off == OFF_EDGE);
  assign we_ctrl   = we & (off == OFF_CTRL);
  assign we_reload = we & (off == OFF_RELOAD);
  assign we_count  = we & (off == OFF_COUNT);
  assign we_status = we & (off == OFF_STATUS);
  pdua_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl[CTRL_EN]),
    .auto_rl  (ctrl[CTRL_AUTO]),
    .psc      (psc_e'(ctrl[CTRL_PSC_HI:CTRL_PSC_LO])),
    .reload   (reload),
    .cnt_we   (we_count),
    .cnt_wdata(wr_data_pr),
    .ctrl_we  (we_ctrl),
    .count    (count),
    .expire   (expire),
    .en_clear (en_clear)
  );
  // A CTRL write wins over the one-shot EN clear; expiry wins over the EXP W1C.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gpo    <= '0;
      gpi_s1 <= '0;
      gpi_s2 <= '0;
      ctrl   <= '0;
      reload <= '0;
      exp_f  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      gpo    <= we_gpo ? wr_data_pr : gpo;
      gpi_s1 <= gpi;
      gpi_s2 <= gpi_s1;
      ctrl   <= we_ctrl ? (wr_data_pr & CTRL_MASK) : en_clear ? (ctrl & ~8'h01) : ctrl;
      reload <= we_reload ? wr_data_pr : reload;
      exp_f  <= expire | (exp_f & ~(we_status & wr_data_pr[0]));
      irq    <= exp_f & ctrl[CTRL_IE];
    end
`ifdef PDUA_PERIPH_EDGE_EN
  logic [7:0] gpi_s3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gpi_s3 <= '0;
      edge_r <= '0;
    end else begin
      gpi_s3 <= gpi_s2;
      edge_r <= (edge_r & ~(we_edge ? wr_data_pr : 8'h00)) | (gpi_s2 & ~gpi_s3);
    end
`else
  assign edge_r = '0;
`endif
  always_comb begin
    rd_data_pr = 8'h00;
    if (hit)
      case (off)
        OFF_GPO:    rd_data_pr = gpo;
        OFF_GPI:    rd_data_pr = gpi_s2;
        OFF_EDGE:   rd_data_pr = edge_r;
        OFF_CTRL:   rd_data_pr = ctrl;
        OFF_RELOAD: rd_data_pr = reload;
        OFF_COUNT:  rd_data_pr = count;
        OFF_STATUS: rd_data_pr = {6'b0, |edge_r, exp_f};
        default:    rd_data_pr = ID_VALUE;
      endcase
  end
endmodule

// File: tb/tb_pdua_periph.sv
// tb_pdua_periph: directed self-checking bench for pdua_periph (edge expectations follow PDUA_PERIPH_EDGE_EN).
module tb_pdua_periph;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       wr = 1'b0;
  logic [7:0] wdat = 8'h00;
  logic [7:0] rd_data_pr;
  logic [7:0] gpi = 8'h00;
  logic [7:0] gpo;
  logic       irq;
  int n_cmp = 0;
  int n_err = 0;
`ifdef PDUA_PERIPH_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  pdua_periph dut (
    .clk        (clk),
    .rst        (rst),
    .addr_bus_pr(addr),
    .wr_rdn_pr  (wr),
    .wr_data_pr (wdat),
    .rd_data_pr (rd_data_pr),
    .gpi        (gpi),
    .gpo        (gpo),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wrr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    wdat = d;
    wr   = 1'b1;
    cyc(1);
    wr   = 1'b0;
  endtask

  task automatic chkrd(input string tag, input logic [7:0] a, input logic [7:0] expv);
    addr = a;
    wr   = 1'b0;
    #1;
    chk(tag, rd_data_pr, expv);
  endtask

  initial begin
    repeat (6) begin
      addr = 8'($urandom);
      wdat = 8'($urandom);
      wr   = 1'b1;
      cyc(1);
    end
    wr = 1'b0;
    chk("rst_gpo", gpo, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 7; i++) chkrd("rst_reg", 8'hF0 + 8'(i), 8'h00);
    chkrd("rst_id", 8'hF7, 8'hA5);
    rst = 1'b1;
    cyc(1);
    // GPO and address decode
    wrr(8'hF0, 8'h3C);
    chk("gpo_wr", gpo, 8'h3C);
    wrr(8'hE0, 8'h55);
    chk("gpo_miss", gpo, 8'h3C);
    chkrd("rd_miss", 8'hE0, 8'h00);
    chkrd("rd_gpo", 8'hF0, 8'h3C);
    wrr(8'hF7, 8'h00);
    chkrd("id_ro", 8'hF7, 8'hA5);
    // GPI synchronizer and edge capture
    gpi = 8'h81;
    cyc(1);
    chkrd("gpi_1", 8'hF1, 8'h00);
    cyc(1);
    chkrd("gpi_2", 8'hF1, 8'h81);
    chkrd("edge_2", 8'hF2, 8'h00);
    cyc(1);
    chkrd("edge_3", 8'hF2, EDGE_ON ? 8'h81 : 8'h00);
    chkrd("stat_edge", 8'hF6, EDGE_ON ? 8'h02 : 8'h00);
    wrr(8'hF2, 8'h01);
    chkrd("edge_w1c", 8'hF2, EDGE_ON ? 8'h80 : 8'h00);
    gpi = 8'h80;
    cyc(4);
    gpi = 8'h81;
    cyc(2);
    wrr(8'hF2, 8'h01);
    chkrd("edge_set_wins", 8'hF2, EDGE_ON ? 8'h81 : 8'h00);
    wrr(8'hF2, 8'hFF);
    chkrd("edge_clr", 8'hF2, 8'h00);
    chkrd("stat_clr", 8'hF6, 8'h00);
    // One-shot, /1
    wrr(8'hF4, 8'h03);
    wrr(8'hF5, 8'h03);
    wrr(8'hF3, 8'h05);
    chkrd("os_cnt0", 8'hF5, 8'h03);
    cyc(3);
    chkrd("os_cnt3", 8'hF5, 8'h00);
    chkrd("os_stat3", 8'hF6, 8'h00);
    cyc(1);
    chkrd("os_exp", 8'hF6, 8'h01);
    chk("os_irq_lag", {7'b0, irq}, 8'h00);
    chkrd("os_ctrl", 8'hF3, 8'h04);
    cyc(1);
    chk("os_irq", {7'b0, irq}, 8'h01);
    chkrd("os_cnt_hold", 8'hF5, 8'h00);
    wrr(8'hF6, 8'h01);
    chkrd("os_w1c", 8'hF6, 8'h00);
    cyc(1);
    chk("os_irq_drop", {7'b0, irq}, 8'h00);
    // Auto-reload, /4
    wrr(8'hF4, 8'h02);
    wrr(8'hF5, 8'h00);
    wrr(8'hF3, 8'h13);
    cyc(3);
    chkrd("ar_pre", 8'hF6, 8'h00);
    cyc(1);
    chkrd("ar_exp1", 8'hF6, 8'h01);
    chkrd("ar_reload1", 8'hF5, 8'h02);
    wrr(8'hF6, 8'h01);
    cyc(3);
    chkrd("ar_t8", 8'hF5, 8'h01);
    cyc(4);
    chkrd("ar_t12", 8'hF5, 8'h00);
    chkrd("ar_t12s", 8'hF6, 8'h00);
    cyc(3);
    chkrd("ar_t15s", 8'hF6, 8'h00);
    cyc(1);
    chkrd("ar_exp2", 8'hF6, 8'h01);
    chkrd("ar_reload2", 8'hF5, 8'h02);
    cyc(3);
    wrr(8'hF5, 8'h77);
    chkrd("ar_cnt_wins", 8'hF5, 8'h77);
    chk("ar_no_irq", {7'b0, irq}, 8'h00);
    // Mid-run asynchronous reset
    wrr(8'hF6, 8'h01);
    wrr(8'hF5, 8'h01);
    wrr(8'hF3, 8'h17);
    cyc(2);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_gpo", gpo, 8'h00);
    chkrd("mr_cnt", 8'hF5, 8'h00);
    chkrd("mr_ctrl", 8'hF3, 8'h00);
    chkrd("mr_reload", 8'hF4, 8'h00);
    cyc(2);
    rst = 1'b1;
    cyc(12);
    chk("mr_irq", {7'b0, irq}, 8'h00);
    chkrd("mr_stat", 8'hF6, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
